bp_update: RTL and testbench

Resolution-side partner of the fetch-stage branch predictor in the LC-3b pipeline.
- Accepts one resolved branch per cycle from the MEM stage and compares the actual outcome with the prediction carried in the control word.
- Issues a registered flush/redirect when they differ, and trains a table of 2-bit saturating counters.
- Queues BTB write requests in a small FIFO drained through a valid/ready handshake into the BTB write port.

---
 rtl/lc3b_types.sv | 40 ++++
 rtl/bp_update_fifo.sv | 61 ++++++
 rtl/bp_update.sv | 144 ++++++++++++++
 tb/tb_bp_update.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b type definitions.
// Contents used by the branch-predictor resolution side:
//   lc3b_word         16-bit machine word
//   lc3b_bp_update_t  BTB write request {pc, target}
//   lc3b_bp_ctr_t     2-bit saturating predictor counter
//   BP_CTR_RESET      counter value after reset (weakly not taken)
//   BP_CTR_STRONG_T   counter value forced by unconditional branches
//   bp_ctr_next()     counter training rule
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef struct packed {
        lc3b_word pc;
        lc3b_word target;
    } lc3b_bp_update_t;

    typedef logic [1:0] lc3b_bp_ctr_t;

    localparam lc3b_bp_ctr_t BP_CTR_RESET    = 2'b01;
    localparam lc3b_bp_ctr_t BP_CTR_STRONG_T = 2'b11;

    // Unconditional branches jump straight to strongly taken; conditional
    // branches step by one and saturate at both ends.
    function automatic lc3b_bp_ctr_t bp_ctr_next(input lc3b_bp_ctr_t ctr,
                                                 input logic taken,
                                                 input logic uncond);
        lc3b_bp_ctr_t nxt;
        nxt = ctr;
        if (uncond) begin
            nxt = BP_CTR_STRONG_T;
        end else if (taken) begin
            if (ctr != 2'b11) nxt = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// bp_update_fifo: synchronous FIFO holding pending BTB writes.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data write request; taken when not full, or when full and
//                   a pop happens in the same cycle
//   pop             read request; ignored while empty
//   pop_data        head entry, read straight from the storage registers
//   full, empty     occupancy flags
// Pointers carry one extra bit so full and empty are distinguishable when
// the index bits match.
module bp_update_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop   = pop & ~empty;
    // When full, the slot being written is the one popped this cycle; the
    // head is read before the edge, so the overwrite is safe.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[PW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/bp_update.sv
// bp_update: resolution-side partner of the fetch-stage branch predictor.
// Compares each resolved branch with its prediction, issues a registered
// flush/redirect on a mispredict, trains a table of 2-bit counters and
// queues BTB writes for taken-but-predicted-not-taken branches.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   res_*               resolved branch from MEM (valid, pc, target, taken,
//                       predicted, uncond)
//   lk_pc / lk_taken    fetch-side lookup; lk_taken is the counter MSB
//   flush, redirect_pc  one-cycle squash and corrected fetch address
//   upd_*               BTB write port (valid/ready)
//   q_overflow          sticky: a BTB write was dropped on a full FIFO
// Optional: define BP_STATS_EN to add saturating stat_resolved and
// stat_mispredict counters.
//
// Handshake: upd_valid stays high and upd_pc/upd_target stay stable until
// the cycle in which upd_ready is also high; that cycle pops the entry.
module bp_update
    import lc3b_types::*;
#(
    parameter int ENTRIES = 8,
    parameter int QDEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        res_valid,
    input  logic [15:0] res_pc,
    input  logic [15:0] res_target,
    input  logic        res_taken,
    input  logic        res_predicted,
    input  logic        res_uncond,
    input  logic [15:0] lk_pc,
    output logic        lk_taken,
    output logic        flush,
    output logic [15:0] redirect_pc,
    output logic        upd_valid,
    input  logic        upd_ready,
    output logic [15:0] upd_pc,
    output logic [15:0] upd_target,
`ifdef BP_STATS_EN
    output logic [15:0] stat_resolved,
    output logic [15:0] stat_mispredict,
`endif
    output logic        q_overflow
);

    localparam int IDX_W = $clog2(ENTRIES);

    lc3b_bp_ctr_t    ctr [ENTRIES];
    logic            mis;
    logic            enq;
    logic            pop;
    logic            q_full;
    logic            q_empty;
    logic [15:0]     redirect_next;
    logic [IDX_W-1:0] res_idx;
    logic [IDX_W-1:0] lk_idx;
    lc3b_bp_update_t push_entry;
    lc3b_bp_update_t head_entry;

    // Instructions are word aligned, so bit 0 never takes part in indexing.
    logic unused_lk_bits;
    assign unused_lk_bits = ^{lk_pc[15:IDX_W+1], lk_pc[0]};

    assign mis     = res_valid & (res_taken != res_predicted);
    assign enq     = res_valid & res_taken & ~res_predicted;
    assign pop     = upd_valid & upd_ready;
    assign res_idx = res_pc[IDX_W:1];
    assign lk_idx  = lk_pc[IDX_W:1];

    assign redirect_next = res_taken ? res_target : (res_pc + 16'd2);

    // Lookup reads the registered table only: no bypass of this cycle's
    // training write.
    assign lk_taken = ctr[lk_idx][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= BP_CTR_RESET;
            end
        end else if (res_valid) begin
            ctr[res_idx] <= bp_ctr_next(ctr[res_idx], res_taken, res_uncond);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush       <= 1'b0;
            redirect_pc <= 16'h0000;
        end else begin
            flush <= mis;
            if (mis) begin
                redirect_pc <= redirect_next;
            end
        end
    end

    assign push_entry.pc     = res_pc;
    assign push_entry.target = res_target;

    bp_update_fifo #(
        .WIDTH($bits(lc3b_bp_update_t)),
        .DEPTH(QDEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (enq),
        .push_data(push_entry),
        .pop      (pop),
        .pop_data (head_entry),
        .full     (q_full),
        .empty    (q_empty)
    );

    assign upd_valid  = ~q_empty;
    assign upd_pc     = head_entry.pc;
    assign upd_target = head_entry.target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_overflow <= 1'b0;
        end else if (enq & q_full & ~pop) begin
            q_overflow <= 1'b1;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved   <= 16'h0000;
            stat_mispredict <= 16'h0000;
        end else begin
            if (res_valid && stat_resolved != 16'hFFFF) begin
                stat_resolved <= stat_resolved + 16'd1;
            end
            if (mis && stat_mispredict != 16'hFFFF) begin
                stat_mispredict <= stat_mispredict + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_update.sv
// tb_bp_update: self-checking bench for bp_update.
// BTB writes expected by the bench go into exp_q when a qualifying branch
// is driven; a monitor pops and compares whenever the DUT completes a
// handshake. Counter expectations come from a small bench-side model.
module tb_bp_update;

    localparam int ENTRIES = 8;
    localparam int QDEPTH  = 4;
    localparam int IDX_W   = 3;

    logic        clk;
    logic        rst_n;
    logic        res_valid;
    logic [15:0] res_pc;
    logic [15:0] res_target;
    logic        res_taken;
    logic        res_predicted;
    logic        res_uncond;
    logic [15:0] lk_pc;
    logic        lk_taken;
    logic        flush;
    logic [15:0] redirect_pc;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_pc;
    logic [15:0] upd_target;
    logic        q_overflow;
`ifdef BP_STATS_EN
    logic [15:0] stat_resolved;
    logic [15:0] stat_mispredict;
`endif

    bp_update #(.ENTRIES(ENTRIES), .QDEPTH(QDEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .res_valid    (res_valid),
        .res_pc       (res_pc),
        .res_target   (res_target),
        .res_taken    (res_taken),
        .res_predicted(res_predicted),
        .res_uncond   (res_uncond),
        .lk_pc        (lk_pc),
        .lk_taken     (lk_taken),
        .flush        (flush),
        .redirect_pc  (redirect_pc),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_pc       (upd_pc),
        .upd_target   (upd_target),
`ifdef BP_STATS_EN
        .stat_resolved  (stat_resolved),
        .stat_mispredict(stat_mispredict),
`endif
        .q_overflow   (q_overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_q[$];
    logic [1:0]  exp_ctr [ENTRIES];
    logic [15:0] exp_redirect;
    int          exp_resolved;
    int          exp_mis;

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < ENTRIES; i++) exp_ctr[i] = 2'b01;
        exp_redirect = 16'h0000;
        exp_resolved = 0;
        exp_mis      = 0;
    endtask

    // ---------------- driver tasks ----------------
    // Called at posedge+1; drives one resolution and returns at the next
    // posedge+1 with res_valid still high (caller decides what follows).
    task automatic resolve(input logic [15:0] pc, input logic [15:0] tgt,
                           input logic taken, input logic pred,
                           input logic unc);
        int idx;
        idx           = int'(pc[IDX_W:1]);
        res_valid     = 1'b1;
        res_pc        = pc;
        res_target    = tgt;
        res_taken     = taken;
        res_predicted = pred;
        res_uncond    = unc;
        exp_resolved++;
        if (taken != pred) begin
            exp_mis++;
            exp_redirect = taken ? tgt : pc + 16'd2;
        end
        if (unc) exp_ctr[idx] = 2'b11;
        else if (taken && exp_ctr[idx] != 2'b11) exp_ctr[idx] = exp_ctr[idx] + 2'b01;
        else if (!taken && exp_ctr[idx] != 2'b00) exp_ctr[idx] = exp_ctr[idx] - 2'b01;
        if (taken && !pred) begin
            if (exp_q.size() < QDEPTH || (upd_ready && exp_q.size() > 0))
                exp_q.push_back({pc, tgt});
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        res_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    // Sampled on the falling edge: a handshake seen here completes at the
    // following rising edge.
    always @(negedge clk) begin
        logic [31:0] exp_e;
        if (rst_n === 1'b1 && upd_valid === 1'b1 && upd_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL btb_pop: got %h with nothing required", {upd_pc, upd_target});
            end else begin
                exp_e = exp_q.pop_front();
                if ({upd_pc, upd_target} !== exp_e) begin
                    n_fail++;
                    $display("FAIL btb_pop: got %h required %h", {upd_pc, upd_target}, exp_e);
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        n_checks++;
        if ({flush, redirect_pc, upd_valid, q_overflow} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b/%h/%b/%b required 0", flush, redirect_pc, upd_valid, q_overflow);
        end
        for (int i = 0; i < ENTRIES; i++) begin
            lk_pc = 16'(i * 2);
            #1;
            n_checks++;
            if (lk_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_lk_taken[%0d]: got %b required 0", i, lk_taken);
            end
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mispredict_taken();
        upd_ready = 1'b0;
        resolve(16'h3000, 16'h3040, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== 16'h3040) begin
            n_fail++;
            $display("FAIL mis_taken_flush: got %b/%h required 1/3040", flush, redirect_pc);
        end
        n_checks++;
        if (upd_valid !== 1'b1 || upd_pc !== 16'h3000 || upd_target !== 16'h3040) begin
            n_fail++;
            $display("FAIL mis_taken_enq: got %b/%h/%h required 1/3000/3040", upd_valid, upd_pc, upd_target);
        end
        idle();
        n_checks++;
        if (flush !== 1'b0 || redirect_pc !== 16'h3040) begin
            n_fail++;
            $display("FAIL mis_taken_one_cycle: got %b/%h required 0/3040", flush, redirect_pc);
        end
        n_checks++;
        if (upd_pc !== 16'h3000) begin
            n_fail++;
            $display("FAIL hold_stable: got %h required 3000", upd_pc);
        end
        upd_ready = 1'b1;
        @(posedge clk); #1;
        upd_ready = 1'b0;
        n_checks++;
        if (upd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_taken_drain: got %b required 0", upd_valid);
        end
    endtask

    task automatic test_mispredict_not_taken();
        resolve(16'hFFFE, 16'h1234, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== 16'h0000 || upd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_not_taken: got %b/%h/%b required 1/0000/0", flush, redirect_pc, upd_valid);
        end
        idle();
        n_checks++;
        if (flush !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_not_taken_clear: got %b required 0", flush);
        end
    endtask

    task automatic test_counter_saturation();
        lk_pc         = 16'h0004;
        res_valid     = 1'b1;
        res_pc        = 16'h0004;
        res_taken     = 1'b1;
        res_predicted = 1'b1;
        res_uncond    = 1'b0;
        #1;
        n_checks++;
        if (lk_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL no_bypass: got %b required 0", lk_taken);
        end
        for (int i = 0; i < 4; i++) begin
            resolve(16'h0004, 16'h0100, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (lk_taken !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_taken[%0d]: got %b required 1", i, lk_taken);
            end
        end
        for (int i = 0; i < 3; i++) begin
            resolve(16'h0004, 16'h0100, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (lk_taken !== exp_ctr[2][1]) begin
                n_fail++;
                $display("FAIL sat_not_taken[%0d]: got %b required %b", i, lk_taken, exp_ctr[2][1]);
            end
        end
        idle();
        n_checks++;
        if (lk_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_final: got %b required 0", lk_taken);
        end
    endtask

    task automatic test_backpressure();
        upd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            resolve(16'h0100 + 16'(2 * i), 16'h2000 + 16'(4 * i), 1'b1, 1'b0, 1'b0);
        end
        idle();
        n_checks++;
        if (q_overflow !== 1'b1 || upd_valid !== 1'b1 || upd_pc !== 16'h0100) begin
            n_fail++;
            $display("FAIL backpressure_hold: got %b/%b/%h required 1/1/0100", q_overflow, upd_valid, upd_pc);
        end
        upd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (upd_valid !== 1'b1 || upd_pc !== 16'h0100 + 16'(2 * i)) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: got %b/%h required 1/%h", i, upd_valid, upd_pc, 16'h0100 + 16'(2 * i));
            end
            @(posedge clk); #1;
        end
        upd_ready = 1'b0;
        n_checks++;
        if (upd_valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_empty: got %b with %0d outstanding required 0/0", upd_valid, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        upd_ready = 1'b0;
        lk_pc     = 16'h000A;
        resolve(16'h000A, 16'h0500, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== 16'h0500 || lk_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL uncond: got %b/%h/%b required 1/0500/1", flush, redirect_pc, lk_taken);
        end
        resolve(16'h000A, 16'h0500, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== 16'h000C || lk_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got %b/%h/%b required 1/000C/1", flush, redirect_pc, lk_taken);
        end
        resolve(16'h000A, 16'h0500, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (flush !== 1'b1 || lk_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: got %b/%b required 1/0", flush, lk_taken);
        end
        idle();
        upd_ready = 1'b1;
        @(posedge clk); #1;
        upd_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        upd_ready = 1'b0;
        resolve(16'h0600, 16'h0700, 1'b1, 1'b0, 1'b0);
        resolve(16'h0602, 16'h0702, 1'b1, 1'b0, 1'b0);
        res_valid = 1'b0;
        n_checks++;
        if (upd_valid !== 1'b1 || flush !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got %b/%b required 1/1", upd_valid, flush);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({flush, redirect_pc, upd_valid, q_overflow, upd_pc, upd_target} !== 51'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %b/%h/%b/%b/%h/%h required 0", flush, redirect_pc, upd_valid, q_overflow, upd_pc, upd_target);
        end
        for (int i = 0; i < ENTRIES; i++) begin
            lk_pc = 16'(i * 2);
            #1;
            n_checks++;
            if (lk_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_lk[%0d]: got %b required 0", i, lk_taken);
            end
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (upd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_valid: got %b required 0", upd_valid);
        end
    endtask

    task automatic test_full_pop();
        int cnt;
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            resolve(16'h0200 + 16'(2 * i), 16'h4000 + 16'(i), 1'b1, 1'b0, 1'b0);
        end
        idle();
        n_checks++;
        if (upd_valid !== 1'b1 || q_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_setup: got %b/%b required 1/0", upd_valid, q_overflow);
        end
        upd_ready = 1'b1;
        resolve(16'h0210, 16'h4010, 1'b1, 1'b0, 1'b0);
        res_valid = 1'b0;
        upd_ready = 1'b0;
        n_checks++;
        if (q_overflow !== 1'b0 || upd_pc !== 16'h0202) begin
            n_fail++;
            $display("FAIL full_pop: got %b/%h required 0/0202", q_overflow, upd_pc);
        end
        upd_ready = 1'b1;
        cnt = 0;
        while (upd_valid === 1'b1 && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        upd_ready = 1'b0;
        n_checks++;
        if (cnt != 4 || q_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop_count: got %0d/%b required 4/0", cnt, q_overflow);
        end
    endtask

`ifdef BP_STATS_EN
    task automatic test_stats();
        n_checks++;
        if (stat_resolved !== 16'(exp_resolved) || stat_mispredict !== 16'(exp_mis)) begin
            n_fail++;
            $display("FAIL stats: got %0d/%0d required %0d/%0d", stat_resolved, stat_mispredict, exp_resolved, exp_mis);
        end
    endtask
`endif

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence / report ----------------
    initial begin
        n_checks      = 0;
        n_fail        = 0;
        res_valid     = 1'b0;
        res_pc        = 16'h0000;
        res_target    = 16'h0000;
        res_taken     = 1'b0;
        res_predicted = 1'b0;
        res_uncond    = 1'b0;
        lk_pc         = 16'h0000;
        upd_ready     = 1'b0;
        test_reset();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_counter_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_full_pop();
`ifdef BP_STATS_EN
        test_stats();
`endif
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
